// File: rtl/fetch_sequencer.sv
// fetch_sequencer: demand-driven instruction fetch between the PC register,
// a byte-wide program memory and the instruction decoder. Reads 1-3 bytes at
// pc, hands the assembled instruction to the decoder over valid/ready, then
// pulses either pc_step (by the instruction size) or pc_load (jump target).
//
// state   | meaning
// --------+-------------------------------------------------------------------
// FETCH0  | read opcode byte at pc; divert to HALTED at the instruction boundary
// FETCH1  | read operand byte 1 at pc+1
// FETCH2  | read operand byte 2 at pc+2
// ISSUE   | present the assembled instruction until the decoder accepts
// UPDATE  | single cycle carrying the pc_step or pc_load pulse
// HALTED  | fetch suspended while halt_req stays high
module fetch_sequencer #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  pc_step,
    output logic [1:0]            step_size,
    output logic                  pc_load,
    output logic [ADDR_WIDTH-1:0] load_addr,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_opcode,
    output logic [DATA_WIDTH-1:0] instr_op1,
    output logic [DATA_WIDTH-1:0] instr_op2,
    output logic [1:0]            instr_size,
    input  logic                  jump_req,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    input  logic                  halt_req,
    output logic                  halted
);

    typedef enum logic [2:0] {
        S_FETCH0 = 3'd0,
        S_FETCH1 = 3'd1,
        S_FETCH2 = 3'd2,
        S_ISSUE  = 3'd3,
        S_UPDATE = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] opcode_q;
    logic [DATA_WIDTH-1:0] op1_q;
    logic [DATA_WIDTH-1:0] op2_q;
    logic [1:0]            size_q;
    logic                  instr_valid_q;
    logic                  pc_step_q;
    logic [1:0]            step_size_q;
    logic                  pc_load_q;
    logic [ADDR_WIDTH-1:0] load_addr_q;
    logic                  halted_q;

    logic [1:0]            rdata_size_d;
    logic                  mem_rd_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;

    // Instruction length from the top two bits of the arriving opcode byte;
    // the reserved code 11 is fetched as a single byte.
    always_comb begin
        case (mem_rdata[DATA_WIDTH-1 -: 2])
            2'b01:   rdata_size_d = 2'd2;
            2'b10:   rdata_size_d = 2'd3;
            default: rdata_size_d = 2'd1;
        endcase
    end

    // Read request follows the fetch state combinationally so FETCH0 always
    // uses the pc written at the end of UPDATE; rst_n gating keeps the memory
    // port quiet while reset is held.
    always_comb begin
        mem_rd_d   = 1'b0;
        mem_addr_d = '0;
        if (rst_n) begin
            case (state_q)
                S_FETCH0: begin
                    if (!halt_req) begin
                        mem_rd_d   = 1'b1;
                        mem_addr_d = pc;
                    end
                end
                S_FETCH1: begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = pc + ADDR_WIDTH'(1);
                end
                S_FETCH2: begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = pc + ADDR_WIDTH'(2);
                end
                default: begin
                    mem_rd_d   = 1'b0;
                    mem_addr_d = '0;
                end
            endcase
        end
    end

    // Sequencer FSM with registered decoder and PC-control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH0;
            opcode_q      <= '0;
            op1_q         <= '0;
            op2_q         <= '0;
            size_q        <= 2'd0;
            instr_valid_q <= 1'b0;
            pc_step_q     <= 1'b0;
            step_size_q   <= 2'd1;
            pc_load_q     <= 1'b0;
            load_addr_q   <= '0;
            halted_q      <= 1'b0;
        end else begin
            pc_step_q <= 1'b0;
            pc_load_q <= 1'b0;
            case (state_q)
                S_FETCH0: begin
                    if (halt_req) begin
                        state_q  <= S_HALTED;
                        halted_q <= 1'b1;
                    end else if (mem_ready) begin
                        opcode_q <= mem_rdata;
                        size_q   <= rdata_size_d;
                        op1_q    <= '0;
                        op2_q    <= '0;
                        if (rdata_size_d >= 2'd2) begin
                            state_q <= S_FETCH1;
                        end else begin
                            state_q       <= S_ISSUE;
                            instr_valid_q <= 1'b1;
                        end
                    end
                end
                S_FETCH1: begin
                    if (mem_ready) begin
                        op1_q <= mem_rdata;
                        if (size_q == 2'd3) begin
                            state_q <= S_FETCH2;
                        end else begin
                            state_q       <= S_ISSUE;
                            instr_valid_q <= 1'b1;
                        end
                    end
                end
                S_FETCH2: begin
                    if (mem_ready) begin
                        op2_q         <= mem_rdata;
                        state_q       <= S_ISSUE;
                        instr_valid_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    // The jump decision is captured into the UPDATE pulse
                    // itself, so the decoder may drop jump_req after accept.
                    if (instr_ready) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= S_UPDATE;
                        if (jump_req) begin
                            pc_load_q   <= 1'b1;
                            load_addr_q <= jump_addr;
                        end else begin
                            pc_step_q   <= 1'b1;
                            step_size_q <= size_q;
                        end
                    end
                end
                S_UPDATE: begin
                    state_q <= S_FETCH0;
                end
                S_HALTED: begin
                    if (!halt_req) begin
                        state_q  <= S_FETCH0;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_FETCH0;
                end
            endcase
        end
    end

    assign mem_rd       = mem_rd_d;
    assign mem_addr     = mem_addr_d;
    assign instr_valid  = instr_valid_q;
    assign instr_opcode = opcode_q;
    assign instr_op1    = op1_q;
    assign instr_op2    = op2_q;
    assign instr_size   = size_q;
    assign pc_step      = pc_step_q;
    assign step_size    = step_size_q;
    assign pc_load      = pc_load_q;
    assign load_addr    = load_addr_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: byte memory model, PC register model, and
// scoreboard queues of expected instructions and PC updates.
module tb_fetch_sequencer;

    localparam int AW = 9;
    localparam int DW = 8;

    typedef struct packed {
        logic [7:0] opc;
        logic [7:0] op1;
        logic [7:0] op2;
        logic [1:0] size;
    } instr_t;

    typedef struct packed {
        logic       is_load;
        logic [1:0] size;
        logic [8:0] addr;
    } upd_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] pc;
    logic          pc_step;
    logic [1:0]    step_size;
    logic          pc_load;
    logic [AW-1:0] load_addr;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic          mem_ready = 1'b1;
    logic [DW-1:0] mem_rdata;
    logic          instr_valid;
    logic          instr_ready = 1'b1;
    logic [DW-1:0] instr_opcode;
    logic [DW-1:0] instr_op1;
    logic [DW-1:0] instr_op2;
    logic [1:0]    instr_size;
    logic          jump_req = 1'b0;
    logic [AW-1:0] jump_addr = '0;
    logic          halt_req = 1'b0;
    logic          halted;

    logic          pc_set = 1'b0;
    logic [AW-1:0] pc_set_val = '0;
    logic [7:0]    mem [0:511];

    int     n_checks = 0;
    int     n_pass = 0;
    bit     overlap_seen = 1'b0;
    instr_t sb_instr[$];
    upd_t   sb_upd[$];

    fetch_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc           (pc),
        .pc_step      (pc_step),
        .step_size    (step_size),
        .pc_load      (pc_load),
        .load_addr    (load_addr),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_op1    (instr_op1),
        .instr_op2    (instr_op2),
        .instr_size   (instr_size),
        .jump_req     (jump_req),
        .jump_addr    (jump_addr),
        .halt_req     (halt_req),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // Garbage on the data bus whenever the memory is not ready.
    assign mem_rdata = mem_ready ? mem[mem_addr] : 8'hEE;

    // PC register model obeying the sequencer's step/load pulses.
    always @(posedge clk) begin
        if (pc_set)       pc <= pc_set_val;
        else if (pc_step) pc <= pc + AW'(step_size);
        else if (pc_load) pc <= load_addr;
    end

    // Record any cycle where step and load pulse together.
    always @(negedge clk) begin
        if (pc_step === 1'b1 && pc_load === 1'b1) overlap_seen = 1'b1;
    end

    task automatic push_instr(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [1:0] s);
        instr_t e;
        e.opc = a; e.op1 = b; e.op2 = c; e.size = s;
        sb_instr.push_back(e);
    endtask

    task automatic push_upd(input logic l, input logic [1:0] s, input logic [8:0] a);
        upd_t u;
        u.is_load = l; u.size = s; u.addr = a;
        sb_upd.push_back(u);
    endtask

    // Hold reset for one cycle while presetting pc, release on a falling edge.
    task automatic apply_reset(input logic [AW-1:0] v);
        @(negedge clk);
        rst_n = 1'b0; pc_set = 1'b1; pc_set_val = v;
        mem_ready = 1'b1; instr_ready = 1'b1; halt_req = 1'b0;
        jump_req = 1'b0; jump_addr = '0;
        @(negedge clk);
        pc_set = 1'b0;
        sb_instr.delete();
        sb_upd.delete();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        logic [59:0] outs;
        @(negedge clk);
        rst_n = 1'b0; pc_set = 1'b1; pc_set_val = '0;
        #1;
        outs = {mem_rd, mem_addr, instr_valid, instr_opcode, instr_op1, instr_op2,
                instr_size, pc_step, pc_load, load_addr, halted};
        n_checks++; if (outs !== '0) $display("FAIL reset_outputs_zero: got=%h exp=0", outs); else n_pass++;
        n_checks++; if (step_size !== 2'd1) $display("FAIL reset_step_size: got=%0d exp=1", step_size); else n_pass++;
        @(negedge clk);
        pc_set = 1'b0; rst_n = 1'b1;
        #1;
        n_checks++; if ({mem_rd, mem_addr} !== {1'b1, 9'h000}) $display("FAIL reset_release_fetch: got=%h exp=%h", {mem_rd, mem_addr}, {1'b1, 9'h000}); else n_pass++;
    endtask

    task automatic test_single_byte();
        instr_t e; upd_t u;
        mem[0] = 8'h05;
        apply_reset(9'h000);
        push_instr(8'h05, 8'h00, 8'h00, 2'd1);
        push_upd(1'b0, 2'd1, 9'h000);
        n_checks++; if ({mem_rd, mem_addr} !== {1'b1, 9'h000}) $display("FAIL single_addr: got=%h exp=%h", {mem_rd, mem_addr}, {1'b1, 9'h000}); else n_pass++;
        @(negedge clk);
        e = sb_instr.pop_front();
        n_checks++; if ({instr_valid, instr_opcode, instr_op1, instr_op2, instr_size} !== {1'b1, e}) $display("FAIL single_issue: got=%h exp=%h", {instr_valid, instr_opcode, instr_op1, instr_op2, instr_size}, {1'b1, e}); else n_pass++;
        @(negedge clk);
        u = sb_upd.pop_front();
        n_checks++; if ({pc_step, pc_load, step_size} !== {~u.is_load, u.is_load, u.size}) $display("FAIL single_step: got=%b exp=%b", {pc_step, pc_load, step_size}, {~u.is_load, u.is_load, u.size}); else n_pass++;
    endtask

    task automatic test_three_byte();
        instr_t e; upd_t u;
        mem[9'h010] = 8'h80; mem[9'h011] = 8'hAA; mem[9'h012] = 8'hBB;
        apply_reset(9'h010);
        push_instr(8'h80, 8'hAA, 8'hBB, 2'd3);
        push_upd(1'b0, 2'd3, 9'h000);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if ({mem_rd, mem_addr} !== {1'b1, AW'(9'h010 + i)}) $display("FAIL three_addr%0d: got=%h exp=%h", i, {mem_rd, mem_addr}, {1'b1, AW'(9'h010 + i)}); else n_pass++;
            @(negedge clk);
        end
        e = sb_instr.pop_front();
        n_checks++; if ({instr_valid, instr_opcode, instr_op1, instr_op2, instr_size} !== {1'b1, e}) $display("FAIL three_issue: got=%h exp=%h", {instr_valid, instr_opcode, instr_op1, instr_op2, instr_size}, {1'b1, e}); else n_pass++;
        @(negedge clk);
        u = sb_upd.pop_front();
        n_checks++; if ({pc_step, pc_load, step_size} !== {~u.is_load, u.is_load, u.size}) $display("FAIL three_step: got=%b exp=%b", {pc_step, pc_load, step_size}, {~u.is_load, u.is_load, u.size}); else n_pass++;
        @(negedge clk);
        n_checks++; if ({pc, mem_addr} !== {9'h013, 9'h013}) $display("FAIL three_next_pc: got=%h exp=%h", {pc, mem_addr}, {9'h013, 9'h013}); else n_pass++;
    endtask

    task automatic test_mem_stall();
        instr_t e; upd_t u;
        mem[9'h020] = 8'h41; mem[9'h021] = 8'h5C;
        apply_reset(9'h020);
        push_instr(8'h41, 8'h5C, 8'h00, 2'd2);
        push_upd(1'b0, 2'd2, 9'h000);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if ({mem_rd, mem_addr, instr_valid, pc_step} !== {1'b1, 9'h021, 1'b0, 1'b0}) $display("FAIL stall_hold%0d: got=%h exp=%h", i, {mem_rd, mem_addr, instr_valid, pc_step}, {1'b1, 9'h021, 1'b0, 1'b0}); else n_pass++;
            mem_ready = (i == 4);
            @(negedge clk);
        end
        e = sb_instr.pop_front();
        n_checks++; if ({instr_valid, instr_opcode, instr_op1, instr_op2, instr_size} !== {1'b1, e}) $display("FAIL stall_issue: got=%h exp=%h", {instr_valid, instr_opcode, instr_op1, instr_op2, instr_size}, {1'b1, e}); else n_pass++;
        @(negedge clk);
        u = sb_upd.pop_front();
        n_checks++; if ({pc_step, pc_load, step_size} !== {~u.is_load, u.is_load, u.size}) $display("FAIL stall_step: got=%b exp=%b", {pc_step, pc_load, step_size}, {~u.is_load, u.is_load, u.size}); else n_pass++;
    endtask

    task automatic test_decoder_stall_jump();
        instr_t e; upd_t u;
        mem[9'h030] = 8'h07;
        apply_reset(9'h030);
        instr_ready = 1'b0;
        push_instr(8'h07, 8'h00, 8'h00, 2'd1);
        push_upd(1'b1, 2'd0, 9'h1F0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if ({instr_valid, instr_opcode, instr_op1, instr_op2, instr_size, pc_step, pc_load} !== {1'b1, sb_instr[0], 2'b00}) $display("FAIL dstall_hold%0d: got=%h exp=%h", i, {instr_valid, instr_opcode, instr_op1, instr_op2, instr_size, pc_step, pc_load}, {1'b1, sb_instr[0], 2'b00}); else n_pass++;
            @(negedge clk);
        end
        instr_ready = 1'b1; jump_req = 1'b1; jump_addr = 9'h1F0;
        e = sb_instr.pop_front();
        n_checks++; if ({instr_valid, instr_opcode, instr_op1, instr_op2, instr_size} !== {1'b1, e}) $display("FAIL dstall_accept: got=%h exp=%h", {instr_valid, instr_opcode, instr_op1, instr_op2, instr_size}, {1'b1, e}); else n_pass++;
        @(negedge clk);
        jump_req = 1'b0; jump_addr = '0;
        u = sb_upd.pop_front();
        n_checks++; if ({pc_step, pc_load, load_addr, instr_valid} !== {~u.is_load, u.is_load, u.addr, 1'b0}) $display("FAIL jump_load: got=%h exp=%h", {pc_step, pc_load, load_addr, instr_valid}, {~u.is_load, u.is_load, u.addr, 1'b0}); else n_pass++;
        @(negedge clk);
        n_checks++; if ({mem_rd, mem_addr} !== {1'b1, 9'h1F0}) $display("FAIL jump_refetch: got=%h exp=%h", {mem_rd, mem_addr}, {1'b1, 9'h1F0}); else n_pass++;
    endtask

    task automatic test_wrap();
        instr_t e; upd_t u;
        logic [AW-1:0] exp_a [3];
        exp_a[0] = 9'h1FF; exp_a[1] = 9'h000; exp_a[2] = 9'h001;
        mem[9'h1FF] = 8'h80; mem[9'h000] = 8'h11; mem[9'h001] = 8'h22;
        apply_reset(9'h1FF);
        push_instr(8'h80, 8'h11, 8'h22, 2'd3);
        push_upd(1'b0, 2'd3, 9'h000);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if ({mem_rd, mem_addr} !== {1'b1, exp_a[i]}) $display("FAIL wrap_addr%0d: got=%h exp=%h", i, {mem_rd, mem_addr}, {1'b1, exp_a[i]}); else n_pass++;
            @(negedge clk);
        end
        e = sb_instr.pop_front();
        n_checks++; if ({instr_valid, instr_opcode, instr_op1, instr_op2, instr_size} !== {1'b1, e}) $display("FAIL wrap_issue: got=%h exp=%h", {instr_valid, instr_opcode, instr_op1, instr_op2, instr_size}, {1'b1, e}); else n_pass++;
        @(negedge clk);
        u = sb_upd.pop_front();
        n_checks++; if ({pc_step, pc_load, step_size} !== {~u.is_load, u.is_load, u.size}) $display("FAIL wrap_step: got=%b exp=%b", {pc_step, pc_load, step_size}, {~u.is_load, u.is_load, u.size}); else n_pass++;
        @(negedge clk);
        n_checks++; if (pc !== 9'h002) $display("FAIL wrap_pc: got=%h exp=002", pc); else n_pass++;
    endtask

    task automatic test_halt();
        instr_t e; upd_t u;
        mem[9'h040] = 8'h42; mem[9'h041] = 8'h33; mem[9'h042] = 8'h01;
        apply_reset(9'h040);
        push_instr(8'h42, 8'h33, 8'h00, 2'd2); push_upd(1'b0, 2'd2, 9'h000);
        push_instr(8'h01, 8'h00, 8'h00, 2'd1); push_upd(1'b0, 2'd1, 9'h000);
        @(negedge clk);
        halt_req = 1'b1;
        n_checks++; if ({mem_rd, mem_addr} !== {1'b1, 9'h041}) $display("FAIL halt_no_abort: got=%h exp=%h", {mem_rd, mem_addr}, {1'b1, 9'h041}); else n_pass++;
        @(negedge clk);
        e = sb_instr.pop_front();
        n_checks++; if ({instr_valid, instr_opcode, instr_op1, instr_op2, instr_size} !== {1'b1, e}) $display("FAIL halt_issue: got=%h exp=%h", {instr_valid, instr_opcode, instr_op1, instr_op2, instr_size}, {1'b1, e}); else n_pass++;
        @(negedge clk);
        u = sb_upd.pop_front();
        n_checks++; if ({pc_step, pc_load, step_size} !== {~u.is_load, u.is_load, u.size}) $display("FAIL halt_step: got=%b exp=%b", {pc_step, pc_load, step_size}, {~u.is_load, u.is_load, u.size}); else n_pass++;
        @(negedge clk);
        n_checks++; if (mem_rd !== 1'b0) $display("FAIL halt_boundary_rd: got=%b exp=0", mem_rd); else n_pass++;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if ({halted, mem_rd, instr_valid} !== 3'b100) $display("FAIL halted%0d: got=%b exp=100", i, {halted, mem_rd, instr_valid}); else n_pass++;
            @(negedge clk);
        end
        halt_req = 1'b0;
        @(negedge clk);
        n_checks++; if ({halted, mem_rd, mem_addr} !== {1'b0, 1'b1, 9'h042}) $display("FAIL halt_resume: got=%h exp=%h", {halted, mem_rd, mem_addr}, {1'b0, 1'b1, 9'h042}); else n_pass++;
        @(negedge clk);
        e = sb_instr.pop_front();
        n_checks++; if ({instr_valid, instr_opcode, instr_op1, instr_op2, instr_size} !== {1'b1, e}) $display("FAIL resume_issue: got=%h exp=%h", {instr_valid, instr_opcode, instr_op1, instr_op2, instr_size}, {1'b1, e}); else n_pass++;
        @(negedge clk);
        u = sb_upd.pop_front();
        n_checks++; if ({pc_step, pc_load, step_size} !== {~u.is_load, u.is_load, u.size}) $display("FAIL resume_step: got=%b exp=%b", {pc_step, pc_load, step_size}, {~u.is_load, u.is_load, u.size}); else n_pass++;
    endtask

    task automatic test_reset_mid();
        instr_t e; upd_t u;
        logic [59:0] outs;
        mem[9'h050] = 8'h80; mem[9'h051] = 8'hC1; mem[9'h052] = 8'hD2;
        apply_reset(9'h050);
        push_instr(8'h80, 8'hC1, 8'hD2, 2'd3);
        push_upd(1'b0, 2'd3, 9'h000);
        @(negedge clk);
        @(negedge clk);
        n_checks++; if ({mem_rd, mem_addr} !== {1'b1, 9'h052}) $display("FAIL rmid_in_fetch2: got=%h exp=%h", {mem_rd, mem_addr}, {1'b1, 9'h052}); else n_pass++;
        rst_n = 1'b0;
        #1;
        outs = {mem_rd, mem_addr, instr_valid, instr_opcode, instr_op1, instr_op2,
                instr_size, pc_step, pc_load, load_addr, halted};
        n_checks++; if (outs !== '0) $display("FAIL rmid_outputs_zero: got=%h exp=0", outs); else n_pass++;
        n_checks++; if (step_size !== 2'd1) $display("FAIL rmid_step_size: got=%0d exp=1", step_size); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if ({mem_rd, mem_addr} !== {1'b1, 9'h050}) $display("FAIL rmid_restart: got=%h exp=%h", {mem_rd, mem_addr}, {1'b1, 9'h050}); else n_pass++;
        repeat (3) @(negedge clk);
        e = sb_instr.pop_front();
        n_checks++; if ({instr_valid, instr_opcode, instr_op1, instr_op2, instr_size} !== {1'b1, e}) $display("FAIL rmid_issue: got=%h exp=%h", {instr_valid, instr_opcode, instr_op1, instr_op2, instr_size}, {1'b1, e}); else n_pass++;
        @(negedge clk);
        u = sb_upd.pop_front();
        n_checks++; if ({pc_step, pc_load, step_size} !== {~u.is_load, u.is_load, u.size}) $display("FAIL rmid_step: got=%b exp=%b", {pc_step, pc_load, step_size}, {~u.is_load, u.is_load, u.size}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        instr_t e; upd_t u;
        int accept_cyc [$];
        mem[9'h060] = 8'h01; mem[9'h061] = 8'h02; mem[9'h062] = 8'h43; mem[9'h063] = 8'h99;
        apply_reset(9'h060);
        push_instr(8'h01, 8'h00, 8'h00, 2'd1); push_upd(1'b0, 2'd1, 9'h000);
        push_instr(8'h02, 8'h00, 8'h00, 2'd1); push_upd(1'b0, 2'd1, 9'h000);
        push_instr(8'h43, 8'h99, 8'h00, 2'd2); push_upd(1'b0, 2'd2, 9'h000);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
                e = sb_instr.pop_front();
                accept_cyc.push_back(cyc);
                n_checks++; if ({instr_opcode, instr_op1, instr_op2, instr_size} !== e) $display("FAIL b2b_issue@%0d: got=%h exp=%h", cyc, {instr_opcode, instr_op1, instr_op2, instr_size}, e); else n_pass++;
            end
            if (pc_step === 1'b1 || pc_load === 1'b1) begin
                u = sb_upd.pop_front();
                n_checks++; if ({pc_step, pc_load, step_size} !== {~u.is_load, u.is_load, u.size}) $display("FAIL b2b_step@%0d: got=%b exp=%b", cyc, {pc_step, pc_load, step_size}, {~u.is_load, u.is_load, u.size}); else n_pass++;
            end
            if (sb_instr.size() == 0 && sb_upd.size() == 0) break;
            @(negedge clk);
        end
        n_checks++; if (sb_instr.size() + sb_upd.size() != 0) $display("FAIL b2b_timeout: got=%0d pending exp=0", sb_instr.size() + sb_upd.size()); else n_pass++;
        n_checks++; if (accept_cyc.size() < 2 || accept_cyc[1] - accept_cyc[0] != 3) $display("FAIL b2b_latency: got=%0d accepts exp=3 cycle spacing", accept_cyc.size()); else n_pass++;
    endtask

    initial begin
        for (int a = 0; a < 512; a++) mem[a] = 8'h00;
        test_reset();
        test_single_byte();
        test_three_byte();
        test_mem_stall();
        test_decoder_stall_jump();
        test_wrap();
        test_halt();
        test_reset_mid();
        test_back_to_back();
        n_checks++; if (overlap_seen !== 1'b0) $display("FAIL step_load_overlap: got=%b exp=0", overlap_seen); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that sequences the program counter and the byte-wide program memory.
- Reads 1–3 instruction bytes starting at the current PC and issues the assembled instruction to the decoder over a valid/ready handshake.
- Then commands the PC to step by the instruction size, or to load a jump target.
- Replaces free-running PC cadence with demand-driven fetch; sits between PC register, program memory and decoder.

Parameters:
- ADDR_WIDTH, 9, program address width; matches PC width.
- DATA_WIDTH, 8, instruction byte width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc  in  ADDR_WIDTH  current PC register value.
- pc_step  out  1  one-cycle pulse: PC advances by step_size.
- step_size  out  2  bytes to advance (1..3); valid with pc_step.
- pc_load  out  1  one-cycle pulse: PC loads load_addr.
- load_addr  out  ADDR_WIDTH  jump target; valid with pc_load.
- mem_rd  out  1  memory read request.
- mem_addr  out  ADDR_WIDTH  read address.
- mem_ready  in  1  memory returns data this cycle.
- mem_rdata  in  DATA_WIDTH  read data, valid when mem_ready.
- instr_valid  out  1  instruction available to decoder.
- instr_ready  in  1  decoder accepts.
- instr_opcode  out  DATA_WIDTH  byte 0.
- instr_op1  out  DATA_WIDTH  byte 1; 0 if size < 2.
- instr_op2  out  DATA_WIDTH  byte 2; 0 if size < 3.
- instr_size  out  2  decoded size.
- jump_req  in  1  decoder requests jump; sampled only on the accept cycle.
- jump_addr  in  ADDR_WIDTH  jump target, sampled with jump_req.
- halt_req  in  1  stop fetching.
- halted  out  1  sequencer is in HALTED.

Behaviour:
- Reset (rst_n low, async):
  - State goes to FETCH0.
  - All outputs 0, including mem_addr, instr_* and load_addr.
  - step_size resets to 1.
- Size decode from opcode[7:6]: 00→1, 01→2, 10→3, 11→1 (reserved, treated as 1-byte).
- States: FETCH0, FETCH1, FETCH2, ISSUE, UPDATE, HALTED.
- FETCH0:
  - If halt_req is high on entry or while waiting, go to HALTED (mem_rd low).
  - Otherwise mem_rd=1, mem_addr=pc.
  - On mem_ready: capture opcode, decode size, clear op1/op2.
  - Next state is FETCH1 if size ≥ 2, else ISSUE.
- FETCH1: mem_rd=1, mem_addr=pc+1. On mem_ready: capture op1; go to FETCH2 if size=3, else ISSUE.
- FETCH2: mem_rd=1, mem_addr=pc+2. On mem_ready: capture op2; go to ISSUE.
- Memory handshake:
  - mem_rd and mem_addr are held stable until the cycle mem_ready is sampled high.
  - mem_ready while mem_rd=0 is ignored.
- Address arithmetic is modulo 2^ADDR_WIDTH; pc+1 and pc+2 wrap (e.g. 511+2 → 1 at width 9).
- ISSUE:
  - instr_valid=1; instr_* held stable until instr_ready.
  - On instr_valid & instr_ready:
    - Latch jump_req/jump_addr; drop instr_valid next cycle.
    - Go to UPDATE.
- UPDATE (exactly one cycle):
  - If the latched jump is set: pc_load=1, load_addr=latched target, pc_step=0.
  - Otherwise: pc_step=1, step_size=instr_size.
  - Next state is FETCH0; the PC register updates at the end of UPDATE, so FETCH0 sees the new pc.
- pc_step and pc_load are never high together, and never high outside UPDATE.
- halt_req:
  - Acts only at an instruction boundary (FETCH0). It never aborts a partial fetch or a pending ISSUE.
  - HALTED: halted=1, mem_rd=0. Leave to FETCH0 the cycle after halt_req is seen low.
- Reset mid-operation: an in-flight fetch is abandoned; no pc_step or pc_load is emitted; the decoder sees instr_valid drop immediately.
- Minimum latency with mem_ready tied high:
  - 1-byte instruction: 3 cycles/instr (FETCH0, ISSUE with ready=1, UPDATE).
  - 3-byte instruction: 5 cycles/instr.

Test Plan:
- Reset, then pc=0, memory {0x05}, mem_ready=1, instr_ready=1 → mem_addr=0; instr_valid in cycle 2 with opcode 0x05, size 1, op1=op2=0; pc_step=1, step_size=1 in cycle 3.
- pc=0x010, memory {0x80,0xAA,0xBB}, mem_ready=1 → reads 0x010, 0x011, 0x012; issues opcode 0x80, op1 0xAA, op2 0xBB, size 3; step_size=3.
- mem_ready low 4 cycles during FETCH1 of opcode 0x41 → mem_rd/mem_addr=pc+1 held stable all 4 cycles; op1 captured on the ready cycle; no pc_step until after accept.
- instr_ready low 5 cycles, then high with jump_req=1, jump_addr=0x1F0 → instr_* stable throughout; next cycle pc_load=1, load_addr=0x1F0, pc_step=0.
- pc=0x1FF, opcode 0x80 → mem_addr sequence 0x1FF, 0x000, 0x001.
- halt_req raised during FETCH1 → current instruction completes with issue and pc_step; then halted=1, mem_rd=0. Drop halt_req → fetch resumes at the new pc. Separately: rst_n pulse during FETCH2 → all outputs 0 asynchronously, restart at FETCH0.
